// File: rtl/stream_pack.sv
// Packs a narrow valid/ready sample stream into Ratio-lane words, LSB lane first.
// Optional idle-timeout flush of partial words is enabled by defining STREAM_PACK_TIMEOUT_EN.
module stream_pack #(
    parameter int InBits        = 8,
    parameter int Ratio         = 4,
    parameter int TimeoutCycles = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [InBits-1:0]           in_data,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [InBits*Ratio-1:0]     out_data,
    output logic                        out_last,
    output logic [$clog2(Ratio):0]      out_count
);
    localparam int CntW = $clog2(Ratio);
    localparam int OcW  = CntW + 1;

    if (Ratio < 2) begin : g_bad_ratio
        $error("stream_pack: Ratio must be at least 2");
    end
    if (TimeoutCycles < 1) begin : g_bad_timeout
        $error("stream_pack: TimeoutCycles must be at least 1");
    end

    logic [Ratio-1:0][InBits-1:0] lane_reg;
    logic [Ratio-1:0][InBits-1:0] word_next;
    logic [CntW-1:0]              cnt_reg;
    logic [InBits*Ratio-1:0]      out_data_reg;
    logic                         out_last_reg;
    logic [OcW-1:0]               out_count_reg;
    logic                         out_valid_reg;

    logic out_free;
    logic accept;
    logic completing;
    logic flush_pending;
    logic flush_fire;
    logic transfer;

    assign out_free   = ~out_valid_reg | out_ready;
    assign in_ready   = out_free & ~flush_pending;
    assign accept     = in_valid & in_ready;
    assign completing = accept & (in_last | (cnt_reg == CntW'(Ratio - 1)));
    assign transfer   = completing | flush_fire;

`ifdef STREAM_PACK_TIMEOUT_EN
    localparam int IdleW = $clog2(TimeoutCycles + 1);
    logic [IdleW-1:0] idle_reg;

    // Saturates at TimeoutCycles; a pending flush blocks input so no beat can race it.
    assign flush_pending = (idle_reg == IdleW'(TimeoutCycles));
    assign flush_fire    = flush_pending & out_free;

    always_ff @(posedge clk) begin
        if (rst || accept || flush_fire || (cnt_reg == '0)) begin
            idle_reg <= '0;
        end else if (!flush_pending) begin
            idle_reg <= idle_reg + IdleW'(1);
        end
    end
`else
    assign flush_pending = 1'b0;
    assign flush_fire    = 1'b0;
`endif

    // The word handed to the output register includes the beat being accepted this cycle.
    for (genvar gi = 0; gi < Ratio; gi++) begin : g_lane
        logic lane_hit;
        assign lane_hit      = accept && (cnt_reg == CntW'(gi));
        assign word_next[gi] = lane_hit ? in_data : lane_reg[gi];

        always_ff @(posedge clk) begin
            if (rst || transfer) begin
                lane_reg[gi] <= '0;
            end else if (lane_hit) begin
                lane_reg[gi] <= in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || transfer) begin
            cnt_reg <= '0;
        end else if (accept) begin
            cnt_reg <= cnt_reg + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_last_reg  <= 1'b0;
            out_count_reg <= '0;
        end else if (transfer) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= word_next;
            out_last_reg  <= completing & in_last;
            out_count_reg <= completing ? OcW'(cnt_reg) + OcW'(1) : OcW'(cnt_reg);
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_last  = out_last_reg;
    assign out_count = out_count_reg;
endmodule
